pump_air_ctrl: RTL and testbench

PUMP_AIR_CTRL -- requirements
Module: pump_air_ctrl

---
 rtl/pump_air_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pump_air_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pump_air_ctrl.sv
// Three-valve peristaltic pump air sequencer: runs a requested number of six-phase
// strokes forward or reverse, holding each phase DWELL cycles, with abort support.
module pump_air_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_strokes,
    input  logic             cmd_dir,
    input  logic             abort,
    output logic [2:0]       air_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] strokes_done
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [2:0]  LAST_PHASE = 3'd5;
    localparam logic [2:0]  AIR_HOLD   = 3'b111;

    state_t           state_r, state_nxt_s;
    logic [2:0]       phase_r, phase_nxt_s;
    logic [15:0]      dwell_r, dwell_nxt_s;
    logic [CNT_W-1:0] target_r, target_nxt_s;
    logic [CNT_W-1:0] strokes_r, strokes_nxt_s;
    logic             dir_r, dir_nxt_s;
    logic [2:0]       air_r, air_nxt_s;
    logic             done_r, done_nxt_s;
    logic             aborted_r, aborted_nxt_s;
    logic             accept_s, phase_end_s, stroke_end_s, run_end_s;
    logic [CNT_W-1:0] strokes_inc_s;

    // Valve pattern for a phase; reverse is the forward table with A and C swapped.
    function automatic logic [2:0] phase_air(input logic dir, input logic [2:0] phase);
        logic [2:0] pat;
        case ({dir, phase})
            4'b0_000: pat = 3'b100;
            4'b0_001: pat = 3'b110;
            4'b0_010: pat = 3'b010;
            4'b0_011: pat = 3'b011;
            4'b0_100: pat = 3'b001;
            4'b0_101: pat = 3'b101;
            4'b1_000: pat = 3'b001;
            4'b1_001: pat = 3'b011;
            4'b1_010: pat = 3'b010;
            4'b1_011: pat = 3'b110;
            4'b1_100: pat = 3'b100;
            4'b1_101: pat = 3'b101;
            default:  pat = 3'b111;
        endcase
        return pat;
    endfunction

    assign accept_s      = cmd_valid && (state_r == IDLE);
    assign phase_end_s   = (state_r == RUN) && (dwell_r == DWELL_LAST);
    assign stroke_end_s  = phase_end_s && (phase_r == LAST_PHASE);
    assign strokes_inc_s = strokes_r + CNT_W'(1'b1);
    assign run_end_s     = stroke_end_s && (strokes_inc_s == target_r);

    // State and registered-output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            phase_r   <= 3'd0;
            dwell_r   <= 16'd0;
            target_r  <= {CNT_W{1'b0}};
            strokes_r <= {CNT_W{1'b0}};
            dir_r     <= 1'b0;
            air_r     <= AIR_HOLD;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            phase_r   <= phase_nxt_s;
            dwell_r   <= dwell_nxt_s;
            target_r  <= target_nxt_s;
            strokes_r <= strokes_nxt_s;
            dir_r     <= dir_nxt_s;
            air_r     <= air_nxt_s;
            done_r    <= done_nxt_s;
            aborted_r <= aborted_nxt_s;
        end
    end

    // Next-state: FSM transition plus phase, dwell and stroke counters.
    always_comb begin
        state_nxt_s   = state_r;
        phase_nxt_s   = phase_r;
        dwell_nxt_s   = dwell_r;
        target_nxt_s  = target_r;
        strokes_nxt_s = strokes_r;
        dir_nxt_s     = dir_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    target_nxt_s  = cmd_strokes;
                    dir_nxt_s     = cmd_dir;
                    strokes_nxt_s = {CNT_W{1'b0}};
                    phase_nxt_s   = 3'd0;
                    dwell_nxt_s   = 16'd0;
                    if (cmd_strokes != {CNT_W{1'b0}}) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                // Abort wins over a coinciding stroke completion, so the partial count stands.
                if (abort) begin
                    state_nxt_s = IDLE;
                    phase_nxt_s = 3'd0;
                    dwell_nxt_s = 16'd0;
                end else if (phase_end_s) begin
                    dwell_nxt_s = 16'd0;
                    if (stroke_end_s) begin
                        strokes_nxt_s = strokes_inc_s;
                        phase_nxt_s   = 3'd0;
                        if (run_end_s) begin
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else begin
                        phase_nxt_s = phase_r + 3'd1;
                    end
                end else begin
                    dwell_nxt_s = dwell_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode: next values of air lines and run-end pulses.
    always_comb begin
        air_nxt_s     = AIR_HOLD;
        done_nxt_s    = 1'b0;
        aborted_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && (cmd_strokes == {CNT_W{1'b0}})) begin
                    done_nxt_s = 1'b1;
                end else if (accept_s) begin
                    air_nxt_s = phase_air(cmd_dir, 3'd0);
                end else begin
                    air_nxt_s = AIR_HOLD;
                end
            end
            RUN: begin
                if (abort) begin
                    done_nxt_s    = 1'b1;
                    aborted_nxt_s = 1'b1;
                end else if (run_end_s) begin
                    done_nxt_s = 1'b1;
                end else begin
                    air_nxt_s = phase_air(dir_r, phase_nxt_s);
                end
            end
            default: begin
                air_nxt_s = AIR_HOLD;
            end
        endcase
    end

    assign cmd_ready    = (state_r == IDLE);
    assign busy         = (state_r == RUN);
    assign air_out      = air_r;
    assign done         = done_r;
    assign aborted      = aborted_r;
    assign strokes_done = strokes_r;

endmodule

// File: tb/tb_pump_air_ctrl.sv
// Bench for pump_air_ctrl (DWELL=2): directed and random runs checked against a
// queue-based model of the expected air pattern and stroke count.
module tb_pump_air_ctrl;
    localparam int D      = 2;
    localparam int STROKE = 6 * D;
    localparam logic [2:0] FWD [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    localparam logic [2:0] REV [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_dir, abort;
    logic       cmd_ready, busy, done, aborted;
    logic [7:0] cmd_strokes, strokes_done;
    logic [2:0] air_out;
    int         tests = 0;
    int         fails = 0;

    pump_air_ctrl #(.DWELL(D), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_strokes(cmd_strokes), .cmd_dir(cmd_dir), .abort(abort),
        .air_out(air_out), .busy(busy), .done(done), .aborted(aborted),
        .strokes_done(strokes_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a command, then follow the run cycle by cycle against the expected pattern queue.
    task automatic run_cmd(input int n, input bit dir, input int abort_at,
                           input bit hold_valid, input bit abort_on_accept);
        logic [2:0] q[$];
        int  last;
        int  exp_sd;
        bit  ab;
        for (int s = 0; s < n; s++)
            for (int p = 0; p < 6; p++)
                for (int d = 0; d < D; d++)
                    q.push_back(dir ? REV[p] : FWD[p]);
        ab   = (abort_at >= 0) && (abort_at < q.size());
        last = ab ? abort_at + 1 : q.size();
        @(negedge clk);
        check("ready_pre", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_strokes = 8'(n); cmd_dir = dir; abort = abort_on_accept;
        @(negedge clk);
        abort = 1'b0; cmd_valid = hold_valid; cmd_strokes = 8'($urandom); cmd_dir = ~dir;
        for (int i = 0; i < last; i++) begin
            check("air_run", 32'(air_out), 32'(q[i]));
            check("busy_run", 32'(busy), 32'd1);
            check("ready_run", 32'(cmd_ready), 32'd0);
            check("done_run", 32'(done), 32'd0);
            check("sd_run", 32'(strokes_done), 32'(i / STROKE));
            abort = (i == abort_at);
            @(negedge clk);
        end
        abort = 1'b0; cmd_valid = 1'b0;
        exp_sd = ab ? abort_at / STROKE : n;
        check("air_end", 32'(air_out), 32'h7);
        check("done_end", 32'(done), 32'd1);
        check("aborted_end", 32'(aborted), 32'(ab));
        check("sd_end", 32'(strokes_done), 32'(exp_sd));
        check("busy_end", 32'(busy), 32'd0);
        check("ready_end", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("done_once", 32'(done), 32'd0);
        check("aborted_once", 32'(aborted), 32'd0);
        check("sd_hold", 32'(strokes_done), 32'(exp_sd));
        check("air_idle", 32'(air_out), 32'h7);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; abort = 1'b0; cmd_strokes = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_air", 32'(air_out), 32'h7);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_sd", 32'(strokes_done), 32'd0);
        rst = 1'b0;

        run_cmd(1, 1'b0, -1, 1'b0, 1'b0);   // forward single stroke
        run_cmd(2, 1'b1, -1, 1'b1, 1'b0);   // reverse, command held while busy
        run_cmd(0, 1'b0, -1, 1'b0, 1'b0);   // zero-stroke command
        run_cmd(3, 1'b0, 14, 1'b0, 1'b0);   // abort in second stroke
        run_cmd(1, 1'b1, STROKE - 1, 1'b0, 1'b0); // abort on final phase edge

        // Abort while idle is ignored.
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("idle_abort_done", 32'(done), 32'd0);
        check("idle_abort_aborted", 32'(aborted), 32'd0);
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_air", 32'(air_out), 32'h7);

        run_cmd(2, 1'b0, -1, 1'b0, 1'b1);   // abort coincident with acceptance

        // Reset mid-run overrides abort and a pending command.
        @(negedge clk); cmd_valid = 1'b1; cmd_strokes = 8'd3; cmd_dir = 1'b0;
        @(negedge clk); cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_sd", 32'(strokes_done), 32'd1);
        rst = 1'b1; abort = 1'b1; cmd_valid = 1'b1;
        @(negedge clk); rst = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
        check("mid_rst_air", 32'(air_out), 32'h7);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_aborted", 32'(aborted), 32'd0);
        check("mid_rst_sd", 32'(strokes_done), 32'd0);
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        run_cmd(1, 1'b0, -1, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int n;
            int ab_at;
            bit hold;
            n     = int'($urandom_range(0, 4));
            ab_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n * STROKE + 2)) : -1;
            hold  = (n > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_cmd(n, 1'($urandom_range(0, 1)), ab_at, hold, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
